ksa_pipe_adder: RTL and testbench
=================================

# ksa_pipe_adder

Parametrised, fully pipelined Kogge-Stone adder/subtractor for the Caravel user area. It accepts one operand pair per cycle over a valid/ready handshake and returns the result a fixed number of cycles later, with one register rank per prefix level. It generalises the fixed 16-bit combinational KSA in three ways: configurable width, carry-in, and add/subtract mode. It sits between the user-project I/O or logic-analyzer glue and any consumer of arithmetic results.

## Interface
- WIDTH, 16, operand width; power of two, 8..64.
- LEVELS, log2(WIDTH), derived constant for the number of prefix levels; not overridable.
- wb_clk_i  input  1  sole clock; rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- in_valid  input  1  an operand pair is present.
- in_ready  output  1  the block can accept an operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; used in add mode only.
- in_sub  input  1  0 = A+B+cin; 1 = A−B (B inverted, cin forced to 1).
- out_valid  output  1  the result is valid.
- out_ready  input  1  the consumer accepts the result.
- out_sum  output  WIDTH  sum or difference, modulo 2^WIDTH.
- out_cout  output  1  carry out of the MSB (in sub mode: 1 = no borrow).
- out_ovf  output  1  two's-complement overflow.
- out_zero  output  1  out_sum == 0.

## Operation
- Stage S0, on accept: b' = in_sub ? ~in_b : in_b; c0 = in_sub | in_cin. Register g = a&b', p = a^b', the raw p for the sum, c0, the MSB signs, and a valid bit.
- Stages S1..S_LEVELS: prefix level k (span 2^(k−1)).
  - For bit i ≥ span: G = G_i | (P_i & G_{i−span}); P = P_i & P_{i−span}.
  - For bit i < span: pass through unchanged.
  - c0 is folded in as a generate into bit −1, i.e. G_0 includes p0&c0.
  - Each level registers G, P, raw p, c0, the sign bits and a valid bit.
- Output stage: sum_i = p_i ^ carry_{i−1}, with carry_{−1} = c0; cout = G_{WIDTH−1}; ovf = carry_{W−1} ^ carry_{W−2}; zero = ~|sum. Register all results together with out_valid.
- Handshake uses a global stall. advance = ~out_valid | out_ready, and in_ready = advance.
  - When advance = 0, every stage, including valid bits and data, holds.
  - When advance = 1, every stage shifts. S0 loads in_valid & in_ready.
  - Bubbles are not compressed.
- Results leave strictly in acceptance order; no result is lost or duplicated.
- Data registers load only when their stage's incoming valid is 1. Outputs stay frozen while out_valid = 0.

## Timing
- Latency: a pair accepted at edge t appears with out_valid = 1 after edge t+LEVELS+1. For WIDTH = 16 this is 5 cycles.
- Throughput: one result per cycle while out_ready = 1.
- in_ready is combinational from out_valid/out_ready only, with no path from in_valid.
- Reset, on the first edge with wb_rst_i = 1:
  - all valid bits 0; out_valid = 0, out_sum = 0, out_cout = out_ovf = out_zero = 0.
  - in_ready = 1 from the cycle after reset.
- Reset mid-stream discards all in-flight operations. A pair presented during reset is not accepted.
- If out_valid = 1 and out_ready = 0, outputs are stable until the handshake completes.
- Simultaneous output handshake and input accept: both occur on the same edge.

## Configuration
- KSA_FLAGS_EN
  - Defined: out_ovf and out_zero are computed, and the sign/flag pipeline bits are present.
  - Undefined: out_ovf and out_zero are tied to 0 and their pipeline bits are removed.
  - out_cout and out_sum are unaffected either way.

## Structure
- Package ksa_pkg holds:
  - the clog2 helper function;
  - the LEVELS derivation;
  - localparam ADD = 1'b0 and SUB = 1'b1 mode encodings.
- Sub-module ksa_prefix_cell is the combinational black cell: (G_i, P_i, G_j, P_j) → (G, P). It is instantiated per bit per level in generate loops; pass-through bits use plain assigns.
- Pipeline registers live in the top module.

## Test plan
- WIDTH=16, add 0xFFFF + 0x0001, cin = 0 → after 5 cycles: sum 0x0000, cout 1, zero 1, ovf 0.
- Sub 0x0005 − 0x0007 → sum 0xFFFE, cout 0 (borrow), ovf 0, zero 0. Add 0x7FFF + 0x0001 → sum 0x8000, ovf 1.
- Back-to-back streaming: 8 random pairs on consecutive cycles with out_ready = 1 → 8 consecutive results, in order, first at cycle +5, all matching the reference model (A±B+cin mod 2^16).
- Backpressure: out_ready = 0 for 3 cycles with the pipeline full → in_ready = 0, out_sum held constant. On release, results resume with no loss or duplication.
- Reset asserted with 3 ops in flight → out_valid = 0 after that edge, all outputs 0, none of the flushed results ever appear.
- Rebuild with WIDTH = 8 and 64, and with KSA_FLAGS_EN undefined:
  - latency is 4 and 7 respectively;
  - 0xFF + 0x01 → sum 0x00, cout 1 at WIDTH = 8;
  - out_ovf and out_zero stay 0 without the macro.

Source files
------------

// File: rtl/ksa_pkg.sv
// ---------------------------------------------------------------------------
// ksa_pkg
// Shared definitions for the pipelined Kogge-Stone adder/subtractor.
//   ADD / SUB  : encodings of the in_sub mode input
//   clog2      : ceiling log2, usable in constant expressions
//   ksaLevels  : number of prefix levels (one pipeline rank each) for a width
// No ports; imported by ksa_pipe_adder and ksa_prefix_cell.
// ---------------------------------------------------------------------------
package ksa_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A W-bit Kogge-Stone tree needs log2(W) doubling steps to span every bit.
    function automatic int ksaLevels(input int width);
        return clog2(width);
    endfunction

endpackage

// File: rtl/ksa_prefix_cell.sv
// ---------------------------------------------------------------------------
// ksa_prefix_cell
// Combinational Kogge-Stone black cell. Merges a higher group (g_hi, p_hi)
// with the adjacent lower group (g_lo, p_lo) into one wider group.
//   g_hi_i, p_hi_i : generate / propagate of the upper group
//   g_lo_i, p_lo_i : generate / propagate of the lower group
//   g_o, p_o       : generate / propagate of the merged group
// ---------------------------------------------------------------------------
module ksa_prefix_cell
    import ksa_pkg::*;
(
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    input  logic p_lo_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
    assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/ksa_pipe_adder.sv
// ---------------------------------------------------------------------------
// ksa_pipe_adder
// Fully pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// One register rank for operand preprocessing (S0), one per prefix level
// (S1..S_LEVELS) and one for the result; latency is LEVELS+1 cycles.
// A single global stall (advance) freezes the whole pipe under backpressure.
//
// Ports:
//   wb_clk_i   clock, rising edge
//   wb_rst_i   synchronous active-high reset
//   in_valid   operand pair present        in_ready   pair accepted this cycle
//   in_a/in_b  operands (WIDTH bits)       in_cin     carry-in (add mode only)
//   in_sub     0: A+B+cin, 1: A-B
//   out_valid  result present              out_ready  consumer accepts result
//   out_sum    result mod 2^WIDTH          out_cout   carry out (sub: 1 = no borrow)
//   out_ovf    two's-complement overflow   out_zero   out_sum == 0
//
// Configuration macro KSA_FLAGS_EN: when defined, out_ovf/out_zero and the
// sign bits feeding them are built; otherwise both outputs are tied to 0.
// ---------------------------------------------------------------------------
module ksa_pipe_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int LEVELS = ksaLevels(WIDTH);

    logic outValid_q;
    logic advance;
    logic accept;

    // Stage k registers; index 0 is S0, index LEVELS feeds the result rank.
    logic [LEVELS:0]            vld_q;
    logic [LEVELS:0][WIDTH-1:0] g_q;
    logic [LEVELS:0][WIDTH-1:0] p_q;
    logic [LEVELS:0][WIDTH-1:0] raw_q;
    logic [LEVELS:0]            c0_q;

    // Combinational output of prefix level k, loaded into stage k.
    logic [LEVELS:1][WIDTH-1:0] g_d;
    logic [LEVELS:1][WIDTH-1:0] p_d;

    logic [WIDTH-1:0] bMod;
    logic [WIDTH-1:0] gIn;
    logic [WIDTH-1:0] pIn;
    logic             c0In;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] outSum_d;
    logic             outCout_d;
    logic [WIDTH-1:0] outSum_q;
    logic             outCout_q;

    // The pipe only moves when the output slot is empty or being drained,
    // so in_ready depends on out_valid/out_ready alone.
    assign advance  = ~outValid_q | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    // Subtraction is A + ~B + 1. The carry-in is folded into bit 0's
    // generate so the prefix tree yields true carries with no extra row.
    always_comb begin
        bMod   = (in_sub == ADD) ? in_b : ~in_b;
        c0In   = (in_sub == SUB) | in_cin;
        pIn    = in_a ^ bMod;
        gIn    = in_a & bMod;
        gIn[0] = gIn[0] | (pIn[0] & c0In);
    end

    // Prefix level k combines each bit with the group 2^(k-1) positions
    // below it; bits with nothing that far below pass through unchanged.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int SPAN = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_cell
                ksa_prefix_cell u_cell (
                    .g_hi_i (g_q[k-1][i]),
                    .p_hi_i (p_q[k-1][i]),
                    .g_lo_i (g_q[k-1][i-SPAN]),
                    .p_lo_i (p_q[k-1][i-SPAN]),
                    .g_o    (g_d[k][i]),
                    .p_o    (p_d[k][i])
                );
            end else begin : g_pass
                assign g_d[k][i] = g_q[k-1][i];
                assign p_d[k][i] = p_q[k-1][i];
            end
        end
    end

    // Valid bits shift together on advance; bubbles are kept, not squeezed.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vld_q      <= '0;
            outValid_q <= 1'b0;
        end else if (advance) begin
            vld_q      <= {vld_q[LEVELS-1:0], accept};
            outValid_q <= vld_q[LEVELS];
        end
    end

    // Data ranks need no reset: each loads only behind a valid bit.
    always_ff @(posedge wb_clk_i) begin
        if (advance) begin
            if (accept) begin
                g_q[0]   <= gIn;
                p_q[0]   <= pIn;
                raw_q[0] <= pIn;
                c0_q[0]  <= c0In;
            end
            for (int k = 1; k <= LEVELS; k++) begin
                if (vld_q[k-1]) begin
                    g_q[k]   <= g_d[k];
                    p_q[k]   <= p_d[k];
                    raw_q[k] <= raw_q[k-1];
                    c0_q[k]  <= c0_q[k-1];
                end
            end
        end
    end

    // After the last level g_q[LEVELS][i] is the carry out of bit i.
    always_comb begin
        carry     = g_q[LEVELS];
        outSum_d  = raw_q[LEVELS] ^ {carry[WIDTH-2:0], c0_q[LEVELS]};
        outCout_d = carry[WIDTH-1];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            outSum_q  <= '0;
            outCout_q <= 1'b0;
        end else if (advance && vld_q[LEVELS]) begin
            outSum_q  <= outSum_d;
            outCout_q <= outCout_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_sum   = outSum_q;
    assign out_cout  = outCout_q;

    // The final group propagate has no consumer once all carries are known.
    logic unusedFinalP;
    assign unusedFinalP = ^p_q[LEVELS];

`ifdef KSA_FLAGS_EN
    logic [LEVELS:0] signA_q;
    logic [LEVELS:0] signB_q;
    logic            outOvf_d;
    logic            outZero_d;
    logic            outOvf_q;
    logic            outZero_q;

    always_ff @(posedge wb_clk_i) begin
        if (advance) begin
            if (accept) begin
                signA_q[0] <= in_a[WIDTH-1];
                signB_q[0] <= bMod[WIDTH-1];
            end
            for (int k = 1; k <= LEVELS; k++) begin
                if (vld_q[k-1]) begin
                    signA_q[k] <= signA_q[k-1];
                    signB_q[k] <= signB_q[k-1];
                end
            end
        end
    end

    // Same-sign operands giving an opposite-sign result is equivalent to
    // carry into the MSB differing from carry out of it.
    assign outOvf_d  = ~(signA_q[LEVELS] ^ signB_q[LEVELS])
                     & (outSum_d[WIDTH-1] ^ signA_q[LEVELS]);
    assign outZero_d = ~|outSum_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            outOvf_q  <= 1'b0;
            outZero_q <= 1'b0;
        end else if (advance && vld_q[LEVELS]) begin
            outOvf_q  <= outOvf_d;
            outZero_q <= outZero_d;
        end
    end

    assign out_ovf  = outOvf_q;
    assign out_zero = outZero_q;
`else
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_ksa_pipe_adder
// Directed bench for ksa_pipe_adder at WIDTH = 16 with hand-computed
// results. A negedge monitor pairs each accepted operand pair with its
// expected result and compares it when the result is handed off.
// Flag expectations follow KSA_FLAGS_EN (forced to 0 when undefined).
// ---------------------------------------------------------------------------
module tb_ksa_pipe_adder;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 5;
`ifdef KSA_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vecT;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } expT;

    logic             wb_clk_i;
    logic             wb_rst_i;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    int  vectorCount = 0;
    int  missCount   = 0;
    expT expQ[$];
    expT curExp;
    expT monExp;
    vecT vecs [0:11];

    ksa_pipe_adder #(.WIDTH(WIDTH)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Holds one vector on the inputs until it is accepted, from posedge+1.
    task automatic applyStimulus(input vecT v);
        bit accepted;
        int waitCycles;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_sub   = v.sub;
        in_valid = 1'b1;
        curExp   = '{sum: v.sum, cout: v.cout, ovf: v.ovf & FLAGS_ON, zero: v.zero & FLAGS_ON};
        accepted   = 1'b0;
        waitCycles = 0;
        while (!accepted && waitCycles < 50) begin
            @(negedge wb_clk_i);
            accepted = in_ready && !wb_rst_i;
            @(posedge wb_clk_i);
            #1;
            waitCycles++;
        end
        if (!accepted) checkOutput("accept timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while (expQ.size() != 0 && k < 50) begin
            @(negedge wb_clk_i);
            k++;
        end
        checkOutput("drain", expQ.size(), 0);
        @(posedge wb_clk_i);
        #1;
    endtask

    // Handshakes are evaluated mid-cycle; they complete on the next posedge.
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            expQ.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected result", 64'd1, 64'd0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("sum",  out_sum,  monExp.sum);
                    checkOutput("cout", out_cout, monExp.cout);
                    checkOutput("ovf",  out_ovf,  monExp.ovf);
                    checkOutput("zero", out_zero, monExp.zero);
                end
            end
            if (in_valid && in_ready) expQ.push_back(curExp);
        end
    end

    initial begin
        int k;
        //          a         b         cin   sub   sum       cout  ovf   zero
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{16'h1000, 16'h2000, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};

        // Reset, with a pair presented that must not be accepted.
        wb_rst_i  = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'h00AA;
        in_b      = 16'h0055;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        curExp    = '0;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_sum",   out_sum,   0);
        checkOutput("reset out_cout",  out_cout,  0);
        checkOutput("reset out_ovf",   out_ovf,   0);
        checkOutput("reset out_zero",  out_zero,  0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        in_valid = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("ready after reset", in_ready, 1);
        @(posedge wb_clk_i);
        #1;

        // Single operation latency, then the corner vectors.
        applyStimulus(vecs[0]);
        k = 0;
        @(negedge wb_clk_i);
        while (!out_valid && k < 50) begin
            @(negedge wb_clk_i);
            k++;
        end
        checkOutput("single latency", k, LATENCY);
        waitDrain();
        applyStimulus(vecs[1]);
        applyStimulus(vecs[2]);
        waitDrain();

        // Back-to-back streaming with the consumer always ready.
        fork
            begin
                for (int i = 3; i <= 10; i++) applyStimulus(vecs[i]);
            end
            begin
                int s;
                @(posedge wb_clk_i);
                s = 0;
                @(negedge wb_clk_i);
                while (!out_valid && s < 50) begin
                    @(negedge wb_clk_i);
                    s++;
                end
                checkOutput("stream latency", s, LATENCY);
                for (int i = 0; i < 8; i++) begin
                    checkOutput("stream valid", out_valid, 1);
                    @(negedge wb_clk_i);
                end
                checkOutput("stream idle", out_valid, 0);
            end
        join
        waitDrain();

        // Backpressure: consumer stalls with the pipeline full.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 3; i <= 10; i++) applyStimulus(vecs[i]);
            end
            begin
                int s;
                s = 0;
                while (!out_valid && s < 50) begin
                    @(negedge wb_clk_i);
                    s++;
                end
                for (int i = 0; i < 3; i++) begin
                    checkOutput("stall in_ready",  in_ready,  0);
                    checkOutput("stall out_valid", out_valid, 1);
                    checkOutput("stall out_sum",   out_sum,   expQ[0].sum);
                    @(negedge wb_clk_i);
                end
                @(posedge wb_clk_i);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with three operations in flight; none may come out.
        applyStimulus(vecs[4]);
        applyStimulus(vecs[5]);
        applyStimulus(vecs[6]);
        wb_rst_i = 1'b1;
        in_valid = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("flush out_valid", out_valid, 0);
        checkOutput("flush out_sum",   out_sum,   0);
        checkOutput("flush out_cout",  out_cout,  0);
        checkOutput("flush out_ovf",   out_ovf,   0);
        checkOutput("flush out_zero",  out_zero,  0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            checkOutput("flush quiet", out_valid, 0);
        end
        @(posedge wb_clk_i);
        #1;

        // Normal operation resumes; cin is ignored in subtract mode.
        applyStimulus(vecs[11]);
        applyStimulus(vecs[1]);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
